// File: rtl/packetgen_pkg.sv
// Shared definitions for the packet-generator flow scheduler: FSM encoding,
// fixed-point defaults and a helper that turns a line rate into a per-cycle credit.
package packetgen_pkg;

   localparam logic [0:0] SCHED_ARB   = 1'b0;
   localparam logic [0:0] SCHED_OFFER = 1'b1;

   localparam int unsigned FRAC_BITS_DEFAULT = 16;
   localparam int unsigned MIN_FRAME_SIZE    = 64;

   // bytes per cycle in Q.FRAC_BITS_DEFAULT for bw_bps bits/s at freq_hz
   function automatic logic [31:0] calc_inc(input longint unsigned bw_bps,
                                            input longint unsigned freq_hz);
      longint unsigned scaled;
      scaled = (bw_bps << FRAC_BITS_DEFAULT) / (64'd8 * freq_hz);
      return 32'(scaled);
   endfunction

endpackage

// File: rtl/packetgen_rr_arbiter.sv
// Rotating-priority picker: first request at or after ptr, searching cyclically.
module packetgen_rr_arbiter #(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant_c,
   output logic [IW-1:0] idx_c,
   output logic          any_req_c
);

   logic [IW:0]   pos;
   logic [IW-1:0] cand;

   always_comb begin
      grant_c   = '0;
      idx_c     = '0;
      any_req_c = 1'b0;
      pos       = '0;
      cand      = '0;
      for (int unsigned k = 0; k < N; k++) begin
         pos = {1'b0, ptr} + (IW+1)'(k);
         if (pos >= (IW+1)'(N)) pos = pos - (IW+1)'(N);
         cand = IW'(pos);
         if (!any_req_c && req[cand]) begin
            any_req_c     = 1'b1;
            grant_c[cand] = 1'b1;
            idx_c         = cand;
         end
      end
   end

endmodule

// File: rtl/packetgen_flow_scheduler.sv
// Per-flow token-bucket scheduler issuing round-robin grants over valid/ready.
// Optional per-flow grant counters on stat_grants when PACKETGEN_SCHED_STATS_EN is defined.
module packetgen_flow_scheduler
   import packetgen_pkg::*;
#(
   parameter int unsigned N_FLOWS      = 4,
   parameter int unsigned SIZE_WIDTH   = 11,
   parameter int unsigned INC_WIDTH    = 32,
   parameter int unsigned FRAC_BITS    = FRAC_BITS_DEFAULT,
   parameter int unsigned CREDIT_WIDTH = 32,
   parameter int unsigned BURST_PKTS   = 2
) (
   input  logic                                           clk,
   input  logic                                           rst,
   input  logic [N_FLOWS-1:0]                             cfg_enable,
   input  logic [N_FLOWS*INC_WIDTH-1:0]                   cfg_inc,
   input  logic [N_FLOWS*SIZE_WIDTH-1:0]                  cfg_size,
   output logic                                           sched_valid,
   input  logic                                           sched_ready,
`ifdef PACKETGEN_SCHED_STATS_EN
   output logic [N_FLOWS*32-1:0]                          stat_grants,
`endif
   output logic [((N_FLOWS > 1) ? $clog2(N_FLOWS) : 1)-1:0] sched_flow,
   output logic [SIZE_WIDTH-1:0]                          sched_size
);

   localparam int unsigned FLOW_W = (N_FLOWS > 1) ? $clog2(N_FLOWS) : 1;
   // one bit of headroom so add/subtract never wrap before clamping
   localparam int unsigned SUM_W  = ((CREDIT_WIDTH > INC_WIDTH) ? CREDIT_WIDTH : INC_WIDTH) + 1;

   logic [0:0]              state_q, state_d;
   logic [FLOW_W-1:0]       rr_q, rr_d;
   logic                    valid_d;
   logic [FLOW_W-1:0]       flow_d;
   logic [SIZE_WIDTH-1:0]   size_d;
   logic [CREDIT_WIDTH-1:0] credit_q [N_FLOWS];
   logic [CREDIT_WIDTH-1:0] credit_d [N_FLOWS];
   logic [N_FLOWS-1:0]      elig_q, elig_d, take;
   logic                    handshake;
   logic [N_FLOWS-1:0]      arb_grant_c;
   logic [FLOW_W-1:0]       arb_idx_c;
   logic                    arb_any_c;
   logic [SIZE_WIDTH-1:0]   pick_size_c;

   assign handshake = sched_valid & sched_ready;

   // Credit accounting; the flow being taken is masked from eligibility for one cycle
   // because its registered credit does not yet reflect the debit.
   for (genvar i = 0; i < int'(N_FLOWS); i++) begin : g_flow
      logic [SUM_W-1:0] thr, cap, sum, debit, net;
      assign take[i]     = handshake & (sched_flow == FLOW_W'(i));
      assign thr         = SUM_W'(cfg_size[i*SIZE_WIDTH +: SIZE_WIDTH]) << FRAC_BITS;
      assign cap         = SUM_W'(BURST_PKTS) * thr;
      assign sum         = SUM_W'(credit_q[i]) + SUM_W'(cfg_inc[i*INC_WIDTH +: INC_WIDTH]);
      assign debit       = take[i] ? (SUM_W'(sched_size) << FRAC_BITS) : '0;
      assign net         = (sum > debit) ? (sum - debit) : '0;
      assign credit_d[i] = !cfg_enable[i] ? '0 :
                           (net > cap)    ? CREDIT_WIDTH'(cap) : CREDIT_WIDTH'(net);
      assign elig_d[i]   = cfg_enable[i] & (SUM_W'(credit_q[i]) >= thr) & ~take[i];
   end

   packetgen_rr_arbiter #(
      .N  (N_FLOWS),
      .IW (FLOW_W)
   ) u_arb (
      .req       (elig_q),
      .ptr       (rr_q),
      .grant_c   (arb_grant_c),
      .idx_c     (arb_idx_c),
      .any_req_c (arb_any_c)
   );

   always_comb begin
      pick_size_c = '0;
      for (int i = 0; i < int'(N_FLOWS); i++) begin
         if (arb_grant_c[i]) pick_size_c = pick_size_c | cfg_size[i*SIZE_WIDTH +: SIZE_WIDTH];
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      valid_d = sched_valid;
      flow_d  = sched_flow;
      size_d  = sched_size;
      case (state_q)
         SCHED_ARB: begin
            if (arb_any_c) begin
               state_d = SCHED_OFFER;
               valid_d = 1'b1;
               flow_d  = arb_idx_c;
               size_d  = pick_size_c;
            end
         end
         SCHED_OFFER: begin
            if (sched_ready) begin
               state_d = SCHED_ARB;
               valid_d = 1'b0;
               rr_d    = (sched_flow == FLOW_W'(N_FLOWS - 1)) ? '0
                                                              : FLOW_W'(sched_flow + FLOW_W'(1));
            end
         end
         default: state_d = SCHED_ARB;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= SCHED_ARB;
         rr_q        <= '0;
         elig_q      <= '0;
         sched_valid <= 1'b0;
         sched_flow  <= '0;
         sched_size  <= '0;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         elig_q      <= elig_d;
         sched_valid <= valid_d;
         sched_flow  <= flow_d;
         sched_size  <= size_d;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < int'(N_FLOWS); i++) begin
         credit_q[i] <= rst ? '0 : credit_d[i];
      end
   end

`ifdef PACKETGEN_SCHED_STATS_EN
   logic [31:0] grant_cnt_q [N_FLOWS];

   always_ff @(posedge clk) begin
      for (int i = 0; i < int'(N_FLOWS); i++) begin
         if (rst)          grant_cnt_q[i] <= '0;
         else if (take[i]) grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
      end
   end

   for (genvar i = 0; i < int'(N_FLOWS); i++) begin : g_stat
      assign stat_grants[i*32 +: 32] = grant_cnt_q[i];
   end
`endif

endmodule

// File: tb/tb_packetgen_flow_scheduler.sv
// Bench for packetgen_flow_scheduler: vector table, hand-written corner sequences and
// randomized traffic against a credit/round-robin reference model.
`timescale 1ns/1ps
module tb_packetgen_flow_scheduler;
   import packetgen_pkg::*;

   localparam int unsigned NF  = 4;
   localparam int unsigned SW  = 11;
   localparam int unsigned IW  = 32;
   localparam longint      ONE = 65536;

   logic              clk = 1'b0;
   logic              rst;
   logic [NF-1:0]     cfg_enable;
   logic [NF*IW-1:0]  cfg_inc;
   logic [NF*SW-1:0]  cfg_size;
   logic              sched_valid;
   logic              sched_ready;
   logic [1:0]        sched_flow;
   logic [SW-1:0]     sched_size;
`ifdef PACKETGEN_SCHED_STATS_EN
   logic [NF*32-1:0]  stat_grants;
`endif

   logic          en_a   [NF];
   logic [IW-1:0] inc_a  [NF];
   logic [SW-1:0] size_a [NF];

   for (genvar g = 0; g < int'(NF); g++) begin : g_pack
      assign cfg_enable[g]          = en_a[g];
      assign cfg_inc[g*IW +: IW]    = inc_a[g];
      assign cfg_size[g*SW +: SW]   = size_a[g];
   end

   packetgen_flow_scheduler dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_enable  (cfg_enable),
      .cfg_inc     (cfg_inc),
      .cfg_size    (cfg_size),
      .sched_valid (sched_valid),
      .sched_ready (sched_ready),
`ifdef PACKETGEN_SCHED_STATS_EN
      .stat_grants (stat_grants),
`endif
      .sched_flow  (sched_flow),
      .sched_size  (sched_size)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // reference model: byte credits as plain integers, one pending offer, RR pointer
   longint m_cred [NF];
   bit     m_elig [NF];
   bit     m_valid;
   int     m_flow, m_size, m_rr;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_edge();
      longint nc [NF];
      bit     ne [NF];
      bit     tk, found;
      longint thr;
      int     j;
      if (rst) begin
         for (int i = 0; i < int'(NF); i++) begin
            m_cred[i] = 0;
            m_elig[i] = 0;
         end
         m_valid = 0; m_flow = 0; m_size = 0; m_rr = 0;
         return;
      end
      for (int i = 0; i < int'(NF); i++) begin
         thr   = longint'(size_a[i]) * ONE;
         tk    = m_valid && sched_ready && (m_flow == i);
         ne[i] = en_a[i] && (m_cred[i] >= thr) && !tk;
         if (!en_a[i]) nc[i] = 0;
         else begin
            nc[i] = m_cred[i] + longint'(inc_a[i]) - (tk ? longint'(m_size) * ONE : 0);
            if (nc[i] < 0) nc[i] = 0;
            if (nc[i] > 2 * thr) nc[i] = 2 * thr;
         end
      end
      if (m_valid) begin
         if (sched_ready) begin
            m_valid = 0;
            m_rr    = (m_flow + 1) % NF;
         end
      end else begin
         found = 0;
         for (int k = 0; k < int'(NF); k++) begin
            j = (m_rr + k) % NF;
            if (!found && m_elig[j]) begin
               found = 1; m_valid = 1; m_flow = j; m_size = int'(size_a[j]);
            end
         end
      end
      m_cred = nc;
      m_elig = ne;
   endtask

   // one clock: advance model with the inputs the DUT sees, then compare outputs
   task automatic step();
      model_edge();
      @(posedge clk);
      @(negedge clk);
      cyc++;
      checks++;
      if (sched_valid !== m_valid ||
          (m_valid && (sched_flow !== 2'(m_flow) || sched_size !== SW'(m_size)))) begin
         errors++;
         $display("FAIL model cyc %0d: got valid=%0b flow=%0d size=%0d expected valid=%0b flow=%0d size=%0d",
                  cyc, sched_valid, sched_flow, sched_size, m_valid, m_flow, m_size);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      cyc = 0;
   endtask

   task automatic all_off();
      for (int i = 0; i < int'(NF); i++) begin
         en_a[i] = 1'b0; inc_a[i] = '0; size_a[i] = SW'(64);
      end
   endtask

   task automatic wait_valid(input int bound, output int t);
      t = -1;
      for (int n = 0; n < bound; n++) begin
         step();
         if (sched_valid) begin
            t = cyc;
            break;
         end
      end
   endtask

   typedef struct {
      int          size;
      logic [31:0] inc;
      int          first;
      int          second;
   } vec_t;

   vec_t vecs [5];

   initial begin
      int first, second, fflow, fsize, t, t0, nval, hs_total;
      int vc [8];
      int vf [8];
      int hs [3];
      int hs_cnt [NF];

      rst = 1'b1;
      sched_ready = 1'b0;
      all_off();
      @(negedge clk);

      // reset state
      do_reset();
      check("reset_valid", sched_valid, 0);
      check("reset_flow", sched_flow, 0);
      check("reset_size", sched_size, 0);

      // single-flow vectors: first and second valid cycle after reset release
      vecs[0] = '{size: 64,   inc: calc_inc(64'd800_000_000, 64'd100_000_000), first: 66,  second: 130};
      vecs[1] = '{size: 100,  inc: 32'd131072,  first: 52,  second: 102};
      vecs[2] = '{size: 64,   inc: 32'd32768,   first: 130, second: 258};
      vecs[3] = '{size: 1500, inc: 32'd1048576, first: 96,  second: 190};
      vecs[4] = '{size: 64,   inc: 32'd0,       first: -1,  second: -1};
      for (int r = 0; r < 5; r++) begin
         all_off();
         en_a[0] = 1'b1; inc_a[0] = vecs[r].inc; size_a[0] = SW'(vecs[r].size);
         sched_ready = 1'b1;
         do_reset();
         first = -1; second = -1; fflow = -1; fsize = -1;
         repeat (300) begin
            step();
            if (sched_valid) begin
               if (first < 0) begin
                  first = cyc; fflow = int'(sched_flow); fsize = int'(sched_size);
               end else if (second < 0) second = cyc;
            end
         end
         check($sformatf("vec%0d_first", r), first, vecs[r].first);
         check($sformatf("vec%0d_second", r), second, vecs[r].second);
         check($sformatf("vec%0d_flow", r), fflow, (vecs[r].first < 0) ? -1 : 0);
         check($sformatf("vec%0d_size", r), fsize, (vecs[r].first < 0) ? -1 : vecs[r].size);
      end

      // four equal flows at 64 B/cycle: strict rotation, one grant per two cycles
      for (int i = 0; i < int'(NF); i++) begin
         en_a[i] = 1'b1; inc_a[i] = 32'(64 * ONE); size_a[i] = SW'(64);
      end
      sched_ready = 1'b1;
      do_reset();
      nval = 0;
      repeat (20) begin
         step();
         if (sched_valid && nval < 8) begin
            vc[nval] = cyc; vf[nval] = int'(sched_flow); nval++;
         end
      end
      check("rr_count", nval, 8);
      for (int k = 0; k < 8; k++) begin
         check($sformatf("rr_cycle%0d", k), vc[k], 3 + 2 * k);
         check($sformatf("rr_flow%0d", k), vf[k], k % 4);
      end

      // saturation: ready held low 500 cycles, credit caps at 200 bytes
      all_off();
      en_a[0] = 1'b1; inc_a[0] = 32'(ONE); size_a[0] = SW'(100);
      sched_ready = 1'b0;
      do_reset();
      repeat (500) step();
      check("sat_valid_held", sched_valid, 1);
      sched_ready = 1'b1;
      nval = 0;
      for (int n = 0; n < 200 && nval < 3; n++) begin
         if (sched_valid) begin
            hs[nval] = cyc; nval++;
         end
         step();
      end
      check("sat_count", nval, 3);
      check("sat_hs0", hs[0], 500);
      check("sat_hs1", hs[1], 503);
      check("sat_hs2", hs[2], 602);

      // flow 2 offered, then resized and disabled while the offer is pending
      all_off();
      en_a[2] = 1'b1; inc_a[2] = 32'(ONE); size_a[2] = SW'(64);
      sched_ready = 1'b0;
      do_reset();
      wait_valid(200, t);
      check("dis_first", t, 66);
      check("dis_flow", sched_flow, 2);
      size_a[2] = SW'(200);
      repeat (3) step();
      check("dis_size_latched", sched_size, 64);
      en_a[2] = 1'b0;
      repeat (3) step();
      check("dis_valid_held", sched_valid, 1);
      check("dis_flow_held", sched_flow, 2);
      sched_ready = 1'b1;
      step();
      check("dis_done", sched_valid, 0);
      nval = 0;
      repeat (100) begin
         step();
         if (sched_valid) nval++;
      end
      check("dis_no_more", nval, 0);
      size_a[2] = SW'(64); en_a[2] = 1'b1;
      t0 = cyc;
      wait_valid(200, t);
      check("dis_credit_zero", (t < 0) ? -1 : t - t0, 66);

      // reset while an offer is pending
      all_off();
      en_a[0] = 1'b1; inc_a[0] = 32'(ONE); size_a[0] = SW'(64);
      sched_ready = 1'b0;
      do_reset();
      wait_valid(200, t);
      check("rst_pre_valid", sched_valid, 1);
      rst = 1'b1;
      step();
      check("rst_valid", sched_valid, 0);
      check("rst_flow", sched_flow, 0);
      check("rst_size", sched_size, 0);
      rst = 1'b0;
      cyc = 0;
      wait_valid(200, t);
      check("rst_credit_zero", t, 66);

      // all flows disabled: nothing offered even with ready high
      all_off();
      sched_ready = 1'b1;
      do_reset();
      nval = 0;
      repeat (100) begin
         step();
         if (sched_valid) nval++;
      end
      check("idle_no_valid", nval, 0);

      // randomized traffic with mid-run reconfiguration and occasional reset
      for (int i = 0; i < int'(NF); i++) begin
         en_a[i] = ($urandom_range(0, 3) != 0);
         inc_a[i] = 32'($urandom_range(0, 48 * 65536));
         size_a[i] = SW'($urandom_range(64, 2047));
      end
      do_reset();
      for (int n = 0; n < 4000; n++) begin
         int f;
         sched_ready = ($urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 799) == 0);
         if ($urandom_range(0, 29) == 0) begin
            f = $urandom_range(0, NF - 1);
            en_a[f] = ($urandom_range(0, 3) != 0);
            inc_a[f] = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(0, 48 * 65536));
            size_a[f] = SW'($urandom_range(64, 2047));
         end
         step();
      end
      rst = 1'b0;

`ifdef PACKETGEN_SCHED_STATS_EN
      // grant counters against handshakes observed by the bench
      for (int i = 0; i < int'(NF); i++) begin
         en_a[i] = 1'b1;
         inc_a[i] = 32'($urandom_range(16, 64) * 65536);
         size_a[i] = SW'($urandom_range(64, 200));
         hs_cnt[i] = 0;
      end
      hs_total = 0;
      do_reset();
      for (int n = 0; n < 20000 && hs_total < 1000; n++) begin
         sched_ready = ($urandom_range(0, 2) != 0);
         if (sched_valid && sched_ready) begin
            hs_cnt[sched_flow]++;
            hs_total++;
         end
         step();
      end
      sched_ready = 1'b0;
      step();
      check("stat_total_hs", hs_total, 1000);
      t = 0;
      for (int i = 0; i < int'(NF); i++) begin
         check($sformatf("stat_flow%0d", i), longint'(stat_grants[i*32 +: 32]), hs_cnt[i]);
         t += int'(stat_grants[i*32 +: 32]);
      end
      check("stat_sum", t, 1000);
`else
      hs_total = 0;
      hs_cnt[0] = 0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
